// File: rtl/qc_ldpc_enc_sequencer.sv
// Schedules the H_info x s circulant products of a QC-LDPC encoder: one ROM
// address per cycle, then aligned clear/accumulate/row-done strobes one cycle later.
module qc_ldpc_enc_sequencer #(
    parameter int Z               = 54,
    parameter int NUM_INFO_BLKS   = 20,
    parameter int NUM_PARITY_BLKS = 4,
    parameter int TOTAL_BLKS      = NUM_INFO_BLKS + NUM_PARITY_BLKS,
    parameter int ADDRW           = $clog2(TOTAL_BLKS * NUM_PARITY_BLKS),
    localparam int COLW = (NUM_INFO_BLKS > 1) ? $clog2(NUM_INFO_BLKS) : 1,
    localparam int ROWW = (NUM_PARITY_BLKS > 1) ? $clog2(NUM_PARITY_BLKS) : 1
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic [ADDRW-1:0] rom_addr,
    output logic             rom_en,
    output logic [COLW-1:0]  blk_sel,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             row_done,
    output logic [ROWW-1:0]  row_idx,
    output logic             done
);

    // Circulant sizes the shift ROM is built for; anything else keeps the block parked.
    localparam bit Z_OK = (Z == 27) || (Z == 54) || (Z == 81);
    localparam logic [ADDRW-1:0] ROW_STEP = ADDRW'(TOTAL_BLKS - NUM_INFO_BLKS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [COLW-1:0]  col_r;
    logic [ROWW-1:0]  row_r;
    logic [ADDRW-1:0] addr_r;
    logic             s1_valid_r;
    logic [COLW-1:0]  s1_col_r;
    logic [ROWW-1:0]  s1_row_r;
    logic             s1_last_r;
    logic             issue_s;
    logic             last_col_s;
    logic             last_row_s;

    assign issue_s    = (state_r == RUN) && !stall;
    assign last_col_s = (col_r == COLW'(NUM_INFO_BLKS - 1));
    assign last_row_s = (row_r == ROWW'(NUM_PARITY_BLKS - 1));

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && Z_OK) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (issue_s && last_col_s && last_row_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (!stall) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Issue counters; the address skips the parity columns at each row wrap.
    always_ff @(posedge CLK) begin
        if (rst) begin
            col_r  <= COLW'(0);
            row_r  <= ROWW'(0);
            addr_r <= ADDRW'(0);
        end else if (issue_s) begin
            if (last_col_s) begin
                col_r <= COLW'(0);
                if (last_row_s) begin
                    row_r  <= ROWW'(0);
                    addr_r <= ADDRW'(0);
                end else begin
                    row_r  <= row_r + ROWW'(1);
                    addr_r <= addr_r + ROW_STEP;
                end
            end else begin
                col_r  <= col_r + COLW'(1);
                addr_r <= addr_r + ADDRW'(1);
            end
        end
    end

    // Data-stage register, aligned with the one-cycle ROM read latency.
    always_ff @(posedge CLK) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_col_r   <= COLW'(0);
            s1_row_r   <= ROWW'(0);
            s1_last_r  <= 1'b0;
        end else if (!stall) begin
            s1_valid_r <= issue_s;
            s1_col_r   <= col_r;
            s1_row_r   <= row_r;
            s1_last_r  <= last_col_s;
        end
    end

    assign busy     = (state_r == RUN) || (state_r == DRAIN);
    assign done     = (state_r == DONE);
    assign rom_en   = issue_s;
    assign rom_addr = addr_r;
    assign acc_en   = s1_valid_r && !stall;
    assign acc_clr  = acc_en && (s1_col_r == COLW'(0));
    assign row_done = acc_en && s1_last_r;
    assign blk_sel  = s1_col_r;
    assign row_idx  = s1_row_r;

endmodule

// File: tb/tb_qc_ldpc_enc_sequencer.sv
// Directed bench for qc_ldpc_enc_sequencer: default geometry plus a 12x12 variant,
// checking every issued address and every accumulator beat against hand-derived values.
module tb_qc_ldpc_enc_sequencer;

    logic clk = 1'b0;
    logic rst, start, stall;
    logic sel;

    logic       a_busy, a_rom_en, a_acc_clr, a_acc_en, a_row_done, a_done;
    logic [6:0] a_rom_addr;
    logic [4:0] a_blk_sel;
    logic [1:0] a_row_idx;
    logic       b_busy, b_rom_en, b_acc_clr, b_acc_en, b_row_done, b_done;
    logic [8:0] b_rom_addr;
    logic [3:0] b_blk_sel;
    logic [3:0] b_row_idx;

    logic        m_busy, m_rom_en, m_acc_clr, m_acc_en, m_row_done, m_done;
    logic [31:0] m_rom_addr, m_blk_sel, m_row_idx;

    int checks = 0;
    int errors = 0;
    int start_cyc[4];
    int stall_cyc[4];

    always #5 clk = ~clk;

    qc_ldpc_enc_sequencer u_dut_a (
        .CLK(clk), .rst(rst), .start(start), .stall(stall),
        .busy(a_busy), .rom_addr(a_rom_addr), .rom_en(a_rom_en), .blk_sel(a_blk_sel),
        .acc_clr(a_acc_clr), .acc_en(a_acc_en), .row_done(a_row_done),
        .row_idx(a_row_idx), .done(a_done)
    );

    qc_ldpc_enc_sequencer #(.Z(27), .NUM_INFO_BLKS(12), .NUM_PARITY_BLKS(12)) u_dut_b (
        .CLK(clk), .rst(rst), .start(start), .stall(stall),
        .busy(b_busy), .rom_addr(b_rom_addr), .rom_en(b_rom_en), .blk_sel(b_blk_sel),
        .acc_clr(b_acc_clr), .acc_en(b_acc_en), .row_done(b_row_done),
        .row_idx(b_row_idx), .done(b_done)
    );

    assign m_busy     = sel ? b_busy     : a_busy;
    assign m_rom_en   = sel ? b_rom_en   : a_rom_en;
    assign m_acc_clr  = sel ? b_acc_clr  : a_acc_clr;
    assign m_acc_en   = sel ? b_acc_en   : a_acc_en;
    assign m_row_done = sel ? b_row_done : a_row_done;
    assign m_done     = sel ? b_done     : a_done;
    assign m_rom_addr = sel ? 32'(b_rom_addr) : 32'(a_rom_addr);
    assign m_blk_sel  = sel ? 32'(b_blk_sel)  : 32'(a_blk_sel);
    assign m_row_idx  = sel ? 32'(b_row_idx)  : 32'(a_row_idx);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit in_list4(input int lst[4], input int v);
        for (int i = 0; i < 4; i++) begin
            if (lst[i] == v) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},     32'(m_busy),     32'd0);
        check_eq({tag, "_rom_en"},   32'(m_rom_en),   32'd0);
        check_eq({tag, "_rom_addr"}, m_rom_addr,      32'd0);
        check_eq({tag, "_blk_sel"},  m_blk_sel,       32'd0);
        check_eq({tag, "_acc_clr"},  32'(m_acc_clr),  32'd0);
        check_eq({tag, "_acc_en"},   32'(m_acc_en),   32'd0);
        check_eq({tag, "_row_done"}, 32'(m_row_done), 32'd0);
        check_eq({tag, "_row_idx"},  m_row_idx,       32'd0);
        check_eq({tag, "_done"},     32'(m_done),     32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Cycle c is the period ending at edge c; start_cyc must contain 0.
    task automatic run_pass(input int ni, input int tot, input int ncyc, input int rst_cyc,
                            input int exp_done, input int exp_beats, input bit end_checks);
        int issue = 0;
        int beat = 0;
        int ndone = 0;
        int done_at = -1;
        for (int c = 0; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start = in_list4(start_cyc, c);
            stall = in_list4(stall_cyc, c);
            rst   = (c == rst_cyc);
            @(negedge clk);
            if (c >= 1) begin
                if (c == 1) check_eq("busy_c1", 32'(m_busy), 32'd1);
                if (rst_cyc >= 0 && c == rst_cyc + 1) check_all_zero("rst_mid");
                if (m_rom_en) begin
                    check_eq("rom_addr", m_rom_addr, 32'((issue / ni) * tot + issue % ni));
                    issue++;
                end
                if (m_acc_en) begin
                    check_eq("blk_sel",  m_blk_sel,        32'(beat % ni));
                    check_eq("row_idx",  m_row_idx,        32'(beat / ni));
                    check_eq("acc_clr",  32'(m_acc_clr),   32'((beat % ni) == 0));
                    check_eq("row_done", 32'(m_row_done),  32'((beat % ni) == ni - 1));
                    beat++;
                end else begin
                    check_eq("idle_clr", 32'(m_acc_clr | m_row_done), 32'd0);
                end
                if (m_done) begin
                    ndone++;
                    done_at = c;
                    check_eq("busy_at_done", 32'(m_busy), 32'd0);
                end
            end
        end
        if (end_checks) begin
            check_eq("done_count", 32'(ndone),   32'd1);
            check_eq("done_cycle", 32'(done_at), 32'(exp_done));
            check_eq("beats",      32'(beat),    32'(exp_beats));
            check_eq("issues",     32'(issue),   32'(exp_beats));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; sel = 1'b0;

        // reset state
        do_reset();
        @(negedge clk);
        check_all_zero("reset");

        // nominal default pass
        start_cyc = '{0, -1, -1, -1};
        stall_cyc = '{-1, -1, -1, -1};
        run_pass(20, 24, 84, -1, 82, 80, 1'b1);

        // stalls at 10..12 and 50
        do_reset();
        start_cyc = '{0, -1, -1, -1};
        stall_cyc = '{10, 11, 12, 50};
        run_pass(20, 24, 88, -1, 86, 80, 1'b1);

        // start while busy and in DONE ignored; start at 83 is accepted
        do_reset();
        start_cyc = '{0, 5, 82, 83};
        stall_cyc = '{-1, -1, -1, -1};
        run_pass(20, 24, 83, -1, 82, 80, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("restart_rom_en", 32'(m_rom_en), 32'd1);
        check_eq("restart_addr",   m_rom_addr,    32'd0);
        check_eq("restart_busy",   32'(m_busy),   32'd1);

        // reset mid-pass at cycle 40, then a full pass starting at cycle 42
        do_reset();
        start_cyc = '{0, -1, -1, -1};
        stall_cyc = '{-1, -1, -1, -1};
        run_pass(20, 24, 41, 40, 0, 0, 1'b0);
        run_pass(20, 24, 84, -1, 82, 80, 1'b1);

        // 12x12 geometry, Z=27
        sel = 1'b1;
        do_reset();
        @(negedge clk);
        check_all_zero("reset_b");
        start_cyc = '{0, -1, -1, -1};
        stall_cyc = '{-1, -1, -1, -1};
        run_pass(12, 24, 148, -1, 146, 144, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
